// File: rtl/mul8_seq_pkg.sv
// Shared constants for the Mega-8 sequential multiplier: operand width,
// iteration count and FSM state encoding (also used by the ALU control decoder).
package mul8_seq_pkg;

   localparam int WIDTH = 8;
   localparam int STEPS = WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul8_seq_adder8.sv
// 8-bit ripple adder; the single arithmetic resource of the Mega-8 datapath.
module adder8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul8_seq.sv
// Multi-cycle 8x8 unsigned shift-and-add multiplier reusing one adder8.
// Handshake: start is accepted only while ready (IDLE); done pulses one cycle with product valid.
module mul8_seq
   import mul8_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [1:0]           dbg_state_o
);

   logic [1:0]            state_q,   state_d;
   logic [WIDTH-1:0]      mcand_q,   mcand_d;
   logic [WIDTH-1:0]      acc_hi_q,  acc_hi_d;
   logic [WIDTH-1:0]      acc_lo_q,  acc_lo_d;
   logic [2:0]            count_q,   count_d;
   logic [2*WIDTH-1:0]    product_q, product_d;

   logic [WIDTH-1:0]      sum;
   logic                  cout;

   adder8 u_adder8 (
      .a_i    (acc_hi_q),
      .b_i    (mcand_q),
      .sum_o  (sum),
      .cout_o (cout)
   );

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mcand_d  = a;
               acc_lo_d = b;
               acc_hi_d = '0;
               count_d  = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // The adder carry re-enters at acc_hi[7] as the accumulator shifts right.
            if (acc_lo_q[0]) begin
               {acc_hi_d, acc_lo_d} = {cout, sum, acc_lo_q[WIDTH-1:1]};
            end else begin
               {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
            end
            count_d = count_q + 3'd1;
            if (count_q == 3'(STEPS - 1)) begin
               product_d = {acc_hi_d, acc_lo_d};
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         mcand_q   <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   assign ready       = (state_q == ST_IDLE);
   assign busy        = (state_q == ST_RUN);
   assign done        = (state_q == ST_DONE);
   assign product     = product_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed bench for mul8_seq: latency, handshake, reset abort and back-to-back operation.
module tb_mul8_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   mul8_seq dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .a           (a),
      .b           (b),
      .ready       (ready),
      .busy        (busy),
      .done        (done),
      .product     (product),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept at the next edge, then check 8 busy cycles, the done cycle and the return to IDLE.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                        input bit hold_and_scramble);
      @(negedge clk);
      chk("ready_before_start", {15'd0, ready}, 16'd1);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      if (hold_and_scramble) begin
         a = 8'h11;
         b = 8'h11;
      end else begin
         start = 1'b0;
         a     = $urandom_range(0, 255);
         b     = $urandom_range(0, 255);
      end
      for (int i = 0; i < 8; i++) begin
         chk("run_busy", {15'd0, busy}, 16'd1);
         chk("run_no_done", {15'd0, done}, 16'd0);
         @(negedge clk);
      end
      chk("done_pulse", {15'd0, done}, 16'd1);
      chk("done_not_busy", {15'd0, busy}, 16'd0);
      chk("product", product, exp);
      start = 1'b0;
      @(negedge clk);
      chk("ready_after_done", {15'd0, ready}, 16'd1);
      chk("done_single", {15'd0, done}, 16'd0);
      chk("product_held", product, exp);
   endtask

   initial begin
      int last_done;
      int n_done;
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      b     = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ready", {15'd0, ready}, 16'd1);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_product", product, 16'h0000);
      chk("rst_state", {14'd0, dbg_state}, 16'd0);
      rst = 1'b0;

      do_op(8'h0D, 8'h0B, 16'h008F, 1'b0);
      do_op(8'hFF, 8'hFF, 16'hFE01, 1'b0);
      do_op(8'h55, 8'h00, 16'h0000, 1'b0);
      do_op(8'h00, 8'hFF, 16'h0000, 1'b0);

      // start held through RUN with new operands: one result, no queued restart
      do_op(8'h80, 8'h02, 16'h0100, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("no_queued_done", {15'd0, done}, 16'd0);
         chk("no_queued_busy", {15'd0, busy}, 16'd0);
         chk("hold_product", product, 16'h0100);
      end

      // reset in the 4th RUN cycle aborts the operation
      @(negedge clk);
      start = 1'b1;
      a     = 8'h12;
      b     = 8'h34;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_before", {15'd0, busy}, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", {15'd0, ready}, 16'd1);
      chk("abort_busy", {15'd0, busy}, 16'd0);
      chk("abort_product", product, 16'h0000);
      repeat (8) begin
         @(negedge clk);
         chk("abort_no_done", {15'd0, done}, 16'd0);
      end
      do_op(8'h12, 8'h34, 16'h03A8, 1'b0);

      // rst and start together: reset wins
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      chk("rst_start_ready", {15'd0, ready}, 16'd1);
      chk("rst_start_busy", {15'd0, busy}, 16'd0);
      chk("rst_start_product", product, 16'h0000);

      // back-to-back with start held: one done every 10 cycles
      @(negedge clk);
      start     = 1'b1;
      a         = 8'h03;
      b         = 8'h07;
      last_done = -1;
      n_done    = 0;
      for (int cyc = 0; cyc < 35; cyc++) begin
         @(negedge clk);
         if (done) begin
            if (n_done == 0) chk("b2b_first_latency", 16'(cyc), 16'd8);
            else             chk("b2b_interval", 16'(cyc - last_done), 16'd10);
            last_done = cyc;
            n_done++;
         end
         if (n_done > 0) chk("b2b_product", product, 16'h0015);
      end
      chk("b2b_done_count", 16'(n_done), 16'd3);
      start = 1'b0;

      begin
         int waited;
         waited = 0;
         while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         chk("final_ready", {15'd0, ready}, 16'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
